ringosc_freq_meter: RTL
=======================

Name: ringosc_freq_meter

Overview:
- Multi-channel gated frequency meter for on-die ring-oscillator experiments. Successor to the single free-running oscillator counter.
- Samples N_CH oscillator outputs into the clk domain and counts rising edges over a programmable gate window. Latches the per-channel counts.
- Exposes one selected byte of one selected channel on an 8-bit output. This maps directly onto the tile's uo_out pins.
- Oscillator signals must be divided upstream to below clk/2. The block does no clock-domain crossing beyond its synchronisers.

Parameters:
- N_CH, 4, number of oscillator channels (1..8).
- CNT_W, 24, edge-counter and result width in bits (8..32).
- GATE_W, 16, width of the gate-length input.
- SYNC_STAGES, 2, synchroniser flops per channel (>=2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- osc_i  in  N_CH  asynchronous divided oscillator inputs.
- start_i  in  1  level; starts a measurement when sampled high in IDLE.
- continuous_i  in  1  when high, rearm automatically after each window.
- gate_len_i  in  GATE_W  gate window length in clk cycles; sampled in ARM.
- ch_sel_i  in  max(1,clog2(N_CH))  channel to present on data_o.
- byte_sel_i  in  max(1,clog2(ceil(CNT_W/8)))  byte of the result to present; 0 = LSB.
- busy_o  out  1  high in ARM or GATE.
- done_o  out  1  one-cycle pulse when results update.
- ovf_o  out  N_CH  per-channel saturation flag of the latest result.
- data_o  out  8  selected byte of the latched result.

Behaviour:
- Reset: rst_n is sampled low at a clk edge. The FSM goes to IDLE.
- Reset clears all counters, results, ovf_o, the synchroniser and edge-detect flops, and the window counter.
- During reset busy_o=0, done_o=0 and data_o=0. Reset mid-window aborts the window with no done_o.
- Synchroniser: each osc_i passes through SYNC_STAGES flops, then one history flop. A rising edge is sync & ~hist.
- FSM states: IDLE, ARM, GATE, LATCH.
- IDLE: leaves to ARM when start_i=1.
- ARM (1 cycle):
  - clear all edge counters;
  - load win = max(gate_len_i,1) (gate_len_i=0 is treated as 1);
  - no edges are counted; go to GATE.
- GATE: each cycle, every channel with a detected rising edge increments its counter.
- GATE window counter: decrements each cycle; after exactly win cycles in GATE, go to LATCH.
- Saturation: a counter at 2^CNT_W-1 holds its value and sets the channel's sticky ovf bit for that window.
- LATCH (1 cycle):
  - copy counters to result registers and ovf bits to ovf_o;
  - pulse done_o in the same cycle the results become visible;
  - if continuous_i=1 go to ARM, else go to IDLE.
- Edges in IDLE, ARM or LATCH are not counted. The dead time between continuous windows is 2 cycles.
- Latency: from the osc_i edge to the count increment is SYNC_STAGES+1 cycles. Edges arriving near a window boundary may land in either window.
- data_o: combinational mux of result[ch_sel_i][8*byte_sel_i +: 8].
  - Bits above CNT_W read 0.
  - ch_sel_i >= N_CH or an out-of-range byte_sel_i reads 0x00.
- Results hold until the next LATCH. start_i and continuous_i changes during GATE do not affect the current window.

Optional Feature:
- Macro RINGOSC_OVF_STOP_EN.
- Defined: in LATCH, if any channel's ovf bit is set, the FSM goes to IDLE even when continuous_i=1. Results and ovf_o are still latched and done_o still pulses.
- Not defined: continuous mode ignores overflow and keeps rearming.

Test Plan:
1. Reset: hold rst_n=0 for 3 clk with osc_i toggling. Then data_o=0x00, busy_o=0, done_o=0, ovf_o=0.
2. Single window: osc_i[0] with period 8 clk, gate_len_i=80, start_i pulse. Then result ch0 = 10 (±1), data_o=0x0A at byte 0, busy_o high for exactly 81 cycles, one done_o pulse.
3. Multi-channel and byte select, CNT_W=24, gate_len_i=0xFFFF:
   - ch1 has period 4, so result 0x003FFF (±1); byte_sel_i=1 gives 0x3F;
   - ch_sel_i=3 with a static osc gives 0x00;
   - byte_sel_i=3 gives 0x00.
4. gate_len_i=0: window of 1 cycle; done_o pulses 3 cycles after start. Counts are 0 or 1.
5. Saturation, CNT_W=8, osc period 4, gate_len_i=2000: result 0xFF and ovf_o[ch]=1.
   - Without RINGOSC_OVF_STOP_EN, continuous_i=1 keeps busy_o cycling.
   - With the macro, the FSM returns to IDLE after the first done_o.
6. Reset mid-GATE: assert rst_n=0 at cycle 40 of an 80-cycle window. No done_o pulses, results are 0, and the next start behaves as in test 2.

Source files
------------

// File: rtl/ringosc_freq_meter_if.sv
// Control/readout bundle of ringosc_freq_meter. The master side starts windows and picks
// the result byte. The slave side (the meter) reports status, overflow and the selected byte.
interface ringosc_freq_meter_if #(
  parameter int N_CH   = 4,
  parameter int CNT_W  = 24,
  parameter int GATE_W = 16
);
  localparam int N_BYTES    = (CNT_W + 7) / 8;
  localparam int CH_SEL_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int BYTE_SEL_W = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

  logic                  start_i;
  logic                  continuous_i;
  logic [GATE_W-1:0]     gate_len_i;
  logic [CH_SEL_W-1:0]   ch_sel_i;
  logic [BYTE_SEL_W-1:0] byte_sel_i;
  logic                  busy_o;
  logic                  done_o;
  logic [N_CH-1:0]       ovf_o;
  logic [7:0]            data_o;

  modport master (
    output start_i, continuous_i, gate_len_i, ch_sel_i, byte_sel_i,
    input  busy_o, done_o, ovf_o, data_o
  );

  modport slave (
    input  start_i, continuous_i, gate_len_i, ch_sel_i, byte_sel_i,
    output busy_o, done_o, ovf_o, data_o
  );
endinterface

// File: rtl/ringosc_freq_meter.sv
// Multi-channel gated ring-oscillator frequency meter: counts synchronised rising edges per channel
// over a programmable window. Optional macro RINGOSC_OVF_STOP_EN stops continuous mode on overflow.
module ringosc_freq_meter #(
  parameter int N_CH        = 4,
  parameter int CNT_W       = 24,
  parameter int GATE_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_CH-1:0]     osc_i,
  ringosc_freq_meter_if.slave bus
);
  localparam int N_BYTES = (CNT_W + 7) / 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, ARM, GATE, LATCH} state_e;

  state_e                           state_q, state_d;
  logic [SYNC_STAGES-1:0][N_CH-1:0] sync_q, sync_d;
  logic [N_CH-1:0]                  hist_q, hist_d;
  logic [N_CH-1:0][CNT_W-1:0]       cnt_q, cnt_d;
  logic [N_CH-1:0][CNT_W-1:0]       result_q, result_d;
  logic [N_CH-1:0]                  ovf_acc_q, ovf_acc_d;
  logic [N_CH-1:0]                  ovf_q, ovf_d;
  logic [GATE_W-1:0]                win_q, win_d;
  logic                             done_q, done_d;
  logic [N_CH-1:0]                  rise;
  logic [N_BYTES*8-1:0]             padded;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; continuous_i only matters in LATCH, so mid-window changes are ignored.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (bus.start_i) state_d = ARM;
      ARM:   state_d = GATE;
      GATE:  if (win_q == GATE_W'(1)) state_d = LATCH;
      LATCH: begin
`ifdef RINGOSC_OVF_STOP_EN
        state_d = (bus.continuous_i && !(|ovf_acc_q)) ? ARM : IDLE;
`else
        state_d = bus.continuous_i ? ARM : IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], osc_i};
    hist_d    = sync_q[SYNC_STAGES-1];
    cnt_d     = cnt_q;
    ovf_acc_d = ovf_acc_q;
    result_d  = result_q;
    ovf_d     = ovf_q;
    win_d     = win_q;
    done_d    = 1'b0;
    unique case (state_q)
      ARM: begin
        cnt_d     = '0;
        ovf_acc_d = '0;
        win_d     = (bus.gate_len_i == '0) ? GATE_W'(1) : bus.gate_len_i;
      end
      GATE: begin
        win_d = win_q - GATE_W'(1);
        for (int ch = 0; ch < N_CH; ch++) begin
          if (rise[ch]) begin
            if (cnt_q[ch] == CNT_MAX) ovf_acc_d[ch] = 1'b1;
            else                      cnt_d[ch]     = cnt_q[ch] + CNT_W'(1);
          end
        end
      end
      LATCH: begin
        result_d = cnt_q;
        ovf_d    = ovf_acc_q;
        done_d   = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: the result registers are reset too, because data_o must read zero straight after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q    <= '0;
      hist_q    <= '0;
      cnt_q     <= '0;
      ovf_acc_q <= '0;
      result_q  <= '0;
      ovf_q     <= '0;
      win_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      hist_q    <= hist_d;
      cnt_q     <= cnt_d;
      ovf_acc_q <= ovf_acc_d;
      result_q  <= result_d;
      ovf_q     <= ovf_d;
      win_q     <= win_d;
      done_q    <= done_d;
    end
  end

  // Outputs; done_o rises on the same edge that loads the result registers.
  always_comb begin
    bus.busy_o  = (state_q == ARM) || (state_q == GATE);
    bus.done_o  = done_q;
    bus.ovf_o   = ovf_q;
    bus.data_o  = 8'h00;
    padded      = '0;
    if ((int'(bus.ch_sel_i) < N_CH) && (int'(bus.byte_sel_i) < N_BYTES)) begin
      padded[CNT_W-1:0] = result_q[bus.ch_sel_i];
      bus.data_o        = padded[8*bus.byte_sel_i +: 8];
    end
  end
endmodule
